// File: rtl/kgp_pkg.sv
// Shared encodings for the multi-cycle datapath: FSM states, control-field
// codes, the registered control bundle and instruction field positions.
package kgp_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_NEG   = 3'd1,
      ALU_AND   = 3'd2,
      ALU_XOR   = 3'd3,
      ALU_SLL   = 3'd4,
      ALU_SRL   = 3'd5,
      ALU_SRA   = 3'd6,
      ALU_PASSB = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_RT    = 2'd0,
      SRC_IMM   = 2'd1,
      SRC_SHAMT = 2'd2,
      SRC_RTSH  = 2'd3
   } alu_src_e;

   typedef enum logic [1:0] {
      WB_RES  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2
   } mem_to_reg_e;

   typedef enum logic [1:0] {
      DST_RS   = 2'd0,
      DST_RT   = 2'd1,
      DST_LAST = 2'd2
   } reg_dest_e;

   typedef enum logic [2:0] {
      BR_SEQ  = 3'd0,
      BR_JUMP = 3'd1,
      BR_REG  = 3'd2,
      BR_NEG  = 3'd3,
      BR_Z    = 3'd4,
      BR_NZ   = 3'd5,
      BR_C    = 3'd6,
      BR_NC   = 3'd7
   } branch_e;

   typedef struct packed {
      reg_dest_e   reg_dest;
      logic        reg_write;
      alu_op_e     alu_op;
      alu_src_e    alu_src;
      logic        mem_write;
      mem_to_reg_e mem_to_reg;
      branch_e     branch;
   } ctrl_t;

   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int SH_LSB  = 11;
   localparam int PDA_W   = 26;

endpackage

// File: rtl/mc_data_path_if.sv
// Instruction and data memory request/ready ports of the datapath.
interface mc_data_path_if #(
   parameter int AW   = 32,
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [AW-1:0]   imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic [AW-1:0]   dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/kgp_alu.sv
// Combinational ALU; carry-out is only meaningful for ALU_ADD.
module kgp_alu
   import kgp_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  alu_op_e         op_i,
   output logic [XLEN-1:0] y_o,
   output logic            c_o
);
   localparam int SW = $clog2(XLEN);

   logic [XLEN:0] sum_s;
   logic [SW-1:0] sh_s;

   // operation select
   always_comb begin
      sum_s = {1'b0, a_i} + {1'b0, b_i};
      sh_s  = b_i[SW-1:0];
      c_o   = sum_s[XLEN];
      case (op_i)
         ALU_ADD:   y_o = sum_s[XLEN-1:0];
         ALU_NEG:   y_o = '0 - b_i;
         ALU_AND:   y_o = a_i & b_i;
         ALU_XOR:   y_o = a_i ^ b_i;
         ALU_SLL:   y_o = a_i << sh_s;
         ALU_SRL:   y_o = a_i >> sh_s;
         ALU_SRA:   y_o = $signed(a_i) >>> sh_s;
         ALU_PASSB: y_o = b_i;
         default:   y_o = '0;
      endcase
   end
endmodule

// File: rtl/mc_data_path.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath with inline register file,
// driven by an external controller that is sampled in DECODE.
module mc_data_path
   import kgp_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   mc_data_path_if.master         mem,
   output logic [5:0]             opcode,
   output logic [5:0]             funccode,
   input  logic [1:0]             reg_dest,
   input  logic                   reg_write,
   input  logic [2:0]             alu_op,
   input  logic [1:0]             alu_src,
   input  logic                   mem_write,
   input  logic [1:0]             mem_to_reg,
   input  logic [2:0]             branch,
   input  logic                   halt_req,
   output logic [AW-1:0]          pc,
   output logic signed [XLEN-1:0] result,
   output logic [2:0]             state,
   output logic                   halted
);
   localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
   typedef logic [XLEN-1:0] word_t;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d, pc_inc_s, br_tgt_s, pc_next_s;
   logic [31:0]   ir_q, ir_d;
   logic          c_q, c_d, z_s, s_s, alu_c_s;
   word_t         result_q, result_d, rs_q, rs_d, rt_q, rt_d, ld_q, ld_d;
   word_t         simm_s, opb_s, alu_y_s, wr_data_s;
   ctrl_t         ctl_q, ctl_d;
   word_t         rf_q [NREG];
   word_t         rf_d [NREG];
   logic          imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
   logic          dmem_we_q, dmem_we_d, halted_q, halted_d, wr_en_s;
   logic [AW-1:0] dmem_addr_q, dmem_addr_d;
   word_t         dmem_wdata_q, dmem_wdata_d;
   logic [RW-1:0] rs_idx_s, rt_idx_s, wr_idx_s;

   kgp_alu #(.XLEN(XLEN)) u_alu (
      .a_i  (rs_q),
      .b_i  (opb_s),
      .op_i (ctl_q.alu_op),
      .y_o  (alu_y_s),
      .c_o  (alu_c_s)
   );

   // operand select, flags, next-pc and writeback selection
   always_comb begin
      rs_idx_s = ir_q[RS_LSB +: RW];
      rt_idx_s = ir_q[RT_LSB +: RW];
      simm_s   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
      z_s      = (result_q == '0);
      s_s      = result_q[XLEN-1];
      pc_inc_s = pc_q + AW'(1'b1);
      br_tgt_s = pc_inc_s + {{(AW-16){ir_q[15]}}, ir_q[15:0]};
      case (ctl_q.alu_src)
         SRC_RT:    opb_s = rt_q;
         SRC_IMM:   opb_s = simm_s;
         SRC_SHAMT: opb_s = word_t'(ir_q[SH_LSB +: 5]);
         SRC_RTSH:  opb_s = word_t'(rt_q[5:0]);
         default:   opb_s = rt_q;
      endcase
      case (ctl_q.branch)
         BR_SEQ:  pc_next_s = pc_inc_s;
         BR_JUMP: pc_next_s = AW'(ir_q[PDA_W-1:0]);
         BR_REG:  pc_next_s = rs_q[AW-1:0];
         BR_NEG:  pc_next_s = s_s ? br_tgt_s : pc_inc_s;
         BR_Z:    pc_next_s = z_s ? br_tgt_s : pc_inc_s;
         BR_NZ:   pc_next_s = z_s ? pc_inc_s : br_tgt_s;
         BR_C:    pc_next_s = c_q ? br_tgt_s : pc_inc_s;
         BR_NC:   pc_next_s = c_q ? pc_inc_s : br_tgt_s;
         default: pc_next_s = pc_inc_s;
      endcase
      case (ctl_q.mem_to_reg)
         WB_RES:  wr_data_s = result_q;
         WB_MEM:  wr_data_s = ld_q;
         WB_LINK: wr_data_s = word_t'(pc_inc_s);
         default: wr_data_s = result_q;
      endcase
      // an undefined destination code suppresses the write
      wr_en_s = ctl_q.reg_write;
      case (ctl_q.reg_dest)
         DST_RS:   wr_idx_s = rs_idx_s;
         DST_RT:   wr_idx_s = rt_idx_s;
         DST_LAST: wr_idx_s = RW'(NREG - 1);
         default: begin
            wr_idx_s = rs_idx_s;
            wr_en_s  = 1'b0;
         end
      endcase
   end

   // FSM next-state and datapath register updates
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      c_d          = c_q;
      result_d     = result_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      ld_d         = ld_q;
      ctl_d        = ctl_q;
      rf_d         = rf_q;
      imem_req_d   = imem_req_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      halted_d     = halted_q;
      case (state_q)
         S_FETCH: begin
            if (imem_req_q && mem.imem_ready) begin
               ir_d       = mem.imem_rdata;
               imem_req_d = 1'b0;
               state_d    = S_DECODE;
            end else begin
               imem_req_d = 1'b1;
            end
         end
         S_DECODE: begin
            rs_d  = rf_q[rs_idx_s];
            rt_d  = rf_q[rt_idx_s];
            ctl_d = '{reg_dest:   reg_dest_e'(reg_dest),
                      reg_write:  reg_write,
                      alu_op:     alu_op_e'(alu_op),
                      alu_src:    alu_src_e'(alu_src),
                      mem_write:  mem_write,
                      mem_to_reg: mem_to_reg_e'(mem_to_reg),
                      branch:     branch_e'(branch)};
            if (halt_req) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = alu_y_s;
            if (ctl_q.alu_op == ALU_ADD) begin
               c_d = alu_c_s;
            end else begin
               c_d = c_q;
            end
            if (ctl_q.mem_write || (ctl_q.mem_to_reg == WB_MEM)) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = ctl_q.mem_write;
               dmem_addr_d  = alu_y_s[AW-1:0];
               dmem_wdata_d = rt_q;
               state_d      = S_MEM;
            end else begin
               state_d      = S_WB;
            end
         end
         S_MEM: begin
            if (mem.dmem_ready) begin
               ld_d       = mem.dmem_rdata;
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               state_d    = S_WB;
            end else begin
               state_d    = S_MEM;
            end
         end
         S_WB: begin
            if (wr_en_s) begin
               rf_d[wr_idx_s] = wr_data_s;
            end else begin
               rf_d = rf_q;
            end
            pc_d       = pc_next_s;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
         end
         default: begin
            state_d    = S_FETCH;
            imem_req_d = 1'b0;
            dmem_req_d = 1'b0;
            dmem_we_d  = 1'b0;
         end
      endcase
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= '0;
         ir_q         <= '0;
         c_q          <= 1'b0;
         result_q     <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         ld_q         <= '0;
         ctl_q        <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         halted_q     <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         c_q          <= c_d;
         result_q     <= result_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         ld_q         <= ld_d;
         ctl_q        <= ctl_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         halted_q     <= halted_d;
         rf_q         <= rf_d;
      end
   end

   assign mem.imem_req   = imem_req_q;
   assign mem.imem_addr  = pc_q;
   assign mem.dmem_req   = dmem_req_q;
   assign mem.dmem_we    = dmem_we_q;
   assign mem.dmem_addr  = dmem_addr_q;
   assign mem.dmem_wdata = dmem_wdata_q;
   assign opcode         = ir_q[OPC_LSB +: 6];
   assign funccode       = ir_q[5:0];
   assign pc             = pc_q;
   assign result         = result_q;
   assign state          = state_q;
   assign halted         = halted_q;
endmodule

// File: tb/tb_mc_data_path.sv
// Scoreboard bench for mc_data_path: the bench plays controller and memories,
// queues expected architectural results per instruction and compares on completion.
module tb_mc_data_path;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 32;

   localparam int K_PC = 0, K_REG = 1, K_C = 2, K_RES = 3, K_CYC = 4;
   localparam int K_MEMC = 5, K_OPC = 6, K_FUNC = 7, K_MEMW = 8, K_HALT = 9, K_ST = 10;

   typedef struct packed {
      logic [1:0] rd;
      logic       rw;
      logic [2:0] op;
      logic [1:0] src;
      logic       mw;
      logic [1:0] m2r;
      logic [2:0] br;
      logic       hlt;
   } ctl_t;

   typedef struct {
      string       tag;
      int          kind;
      int          idx;
      logic [63:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [5:0] opcode, funccode;
   logic [1:0] reg_dest, alu_src, mem_to_reg;
   logic [2:0] alu_op, branch, state;
   logic reg_write, mem_write, halt_req, halted;
   logic [AW-1:0] pc;
   logic signed [XLEN-1:0] result;

   mc_data_path_if #(.AW(AW), .XLEN(XLEN)) mif ();

   mc_data_path #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem        (mif),
      .opcode     (opcode),
      .funccode   (funccode),
      .reg_dest   (reg_dest),
      .reg_write  (reg_write),
      .alu_op     (alu_op),
      .alu_src    (alu_src),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .branch     (branch),
      .halt_req   (halt_req),
      .pc         (pc),
      .result     (result),
      .state      (state),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int last_cyc, last_memc;
   logic [31:0] dmem_mem [64];
   exp_t sb_q[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   function automatic ctl_t mk_ctl(input int rd, rw, op, src, mw, m2r, br, hlt);
      ctl_t c;
      c = '{rd: 2'(rd), rw: 1'(rw), op: 3'(op), src: 2'(src), mw: 1'(mw),
            m2r: 2'(m2r), br: 3'(br), hlt: 1'(hlt)};
      return c;
   endfunction

   task automatic push_exp(input string tag, input int kind, input int idx, input logic [63:0] v);
      exp_t e;
      e.tag = tag; e.kind = kind; e.idx = idx; e.val = v;
      sb_q.push_back(e);
   endtask

   function automatic logic [63:0] obs_val(input int kind, input int idx);
      case (kind)
         K_PC:    return 64'(pc);
         K_REG:   return 64'(dut.rf_q[idx]);
         K_C:     return 64'(dut.c_q);
         K_RES:   return 64'(result);
         K_CYC:   return 64'(last_cyc);
         K_MEMC:  return 64'(last_memc);
         K_OPC:   return 64'(opcode);
         K_FUNC:  return 64'(funccode);
         K_MEMW:  return 64'(dmem_mem[idx]);
         K_HALT:  return 64'(halted);
         K_ST:    return 64'(state);
         default: return 64'hDEAD_0000_0000_0000;
      endcase
   endfunction

   // Drive one instruction from FETCH until the DUT returns to FETCH or HALT, then drain the scoreboard.
   task automatic run_instr(input logic [31:0] iw, input ctl_t c, input int dly,
                            input logic [AW-1:0] exp_addr, input logic [31:0] exp_wdata);
      int cyc = 0;
      int memc = 0;
      exp_t e;
      mif.imem_rdata = iw;
      mif.imem_ready = 1'b1;
      reg_dest = c.rd; reg_write = c.rw; alu_op = c.op; alu_src = c.src;
      mem_write = c.mw; mem_to_reg = c.m2r; branch = c.br; halt_req = c.hlt;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         mif.dmem_ready = 1'b0;
         if (mif.imem_req && mif.dmem_req) check_val("req_exclusive", 64'd1, 64'd0);
         if (state == 3'd3) begin
            check_val("dmem_addr", 64'(mif.dmem_addr), 64'(exp_addr));
            check_val("dmem_we", 64'(mif.dmem_we), 64'(c.mw));
            if (c.mw) check_val("dmem_wdata", 64'(mif.dmem_wdata), 64'(exp_wdata));
            if (memc == dly) begin
               mif.dmem_ready = 1'b1;
               mif.dmem_rdata = dmem_mem[mif.dmem_addr[5:0]];
               if (mif.dmem_we) dmem_mem[mif.dmem_addr[5:0]] = mif.dmem_wdata;
            end
            memc++;
         end
      end while (state != 3'd0 && state != 3'd5 && cyc < 40);
      if (cyc >= 40) check_val("instr_timeout", 64'(cyc), 64'd0);
      last_cyc  = cyc;
      last_memc = memc;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, obs_val(e.kind, e.idx), e.val);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) dmem_mem[i] = 32'h0;
      dmem_mem[16] = 32'hDEADBEEF;
      rst = 1'b1;
      mif.imem_ready = 1'b1; mif.imem_rdata = 32'h0;
      mif.dmem_ready = 1'b0; mif.dmem_rdata = 32'h0;
      reg_dest = 2'd0; reg_write = 1'b0; alu_op = 3'd0; alu_src = 2'd0;
      mem_write = 1'b0; mem_to_reg = 2'd0; branch = 3'd0; halt_req = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_state", 64'(state), 64'd0);
      check_val("rst_pc", 64'(pc), 64'd0);
      check_val("rst_imem_req", 64'(mif.imem_req), 64'd0);
      check_val("rst_dmem_req", 64'(mif.dmem_req), 64'd0);
      check_val("rst_result", 64'(result), 64'd0);
      check_val("rst_halted", 64'(halted), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("first_fetch_req", 64'(mif.imem_req), 64'd1);

      // r5 = 1 (pass sext imm into rt)
      push_exp("seed_r5", K_REG, 5, 64'd1);
      push_exp("seed_pc", K_PC, 0, 64'd1);
      run_instr({6'h08, 5'd0, 5'd5, 16'h0001}, mk_ctl(1, 1, 7, 1, 0, 0, 0, 0), 0, '0, '0);

      // addi r5 = r5 + sext(0xFFFF): wraps to 0 with carry
      push_exp("addi_r5", K_REG, 5, 64'd0);
      push_exp("addi_c", K_C, 0, 64'd1);
      push_exp("addi_pc", K_PC, 0, 64'd2);
      push_exp("addi_cycles", K_CYC, 0, 64'd4);
      push_exp("addi_result", K_RES, 0, 64'd0);
      run_instr({6'h08, 5'd5, 5'd0, 16'hFFFF}, mk_ctl(0, 1, 0, 1, 0, 0, 0, 0), 0, '0, '0);

      // load r6 <- mem[0x10] with dmem_ready three cycles late
      push_exp("load_r6", K_REG, 6, 64'hDEADBEEF);
      push_exp("load_c", K_C, 0, 64'd0);
      push_exp("load_cycles", K_CYC, 0, 64'd8);
      push_exp("load_mem_cycles", K_MEMC, 0, 64'd4);
      push_exp("load_pc", K_PC, 0, 64'd3);
      run_instr({6'h23, 5'd0, 5'd6, 16'h0010}, mk_ctl(1, 1, 0, 1, 0, 1, 0, 0), 3, 32'h10, '0);

      // call at pc=3: r31 = pc+1, jump to 0x40
      push_exp("call_r31", K_REG, 31, 64'd4);
      push_exp("call_pc", K_PC, 0, 64'h40);
      push_exp("call_opcode", K_OPC, 0, 64'h03);
      run_instr({6'h03, 26'h40}, mk_ctl(2, 1, 7, 0, 0, 2, 1, 0), 0, '0, '0);

      // store r6 -> mem[0x20], zero wait
      push_exp("store_cycles", K_CYC, 0, 64'd5);
      push_exp("store_pc", K_PC, 0, 64'h41);
      push_exp("store_mem", K_MEMW, 32, 64'hDEADBEEF);
      run_instr({6'h2B, 5'd0, 5'd6, 16'h0020}, mk_ctl(1, 0, 0, 1, 1, 0, 0, 0), 0, 32'h20, 32'hDEADBEEF);

      // jump to 7
      push_exp("jump_pc", K_PC, 0, 64'd7);
      run_instr({6'h02, 26'd7}, mk_ctl(0, 0, 7, 0, 0, 0, 1, 0), 0, '0, '0);

      // bz at pc=7, imm=-2, r6^r6 = 0 -> taken to 6
      push_exp("bz_taken_pc", K_PC, 0, 64'd6);
      push_exp("bz_taken_res", K_RES, 0, 64'd0);
      run_instr({6'h04, 5'd6, 5'd6, 16'hFFFE}, mk_ctl(0, 0, 3, 0, 0, 0, 4, 0), 0, '0, '0);

      // add without writeback at pc=6 sets C and falls through to 7
      push_exp("add_c_set", K_C, 0, 64'd1);
      push_exp("add_nowr_r6", K_REG, 6, 64'hDEADBEEF);
      push_exp("add_pc", K_PC, 0, 64'd7);
      run_instr({6'h08, 5'd6, 5'd0, 16'hFFFF}, mk_ctl(0, 0, 0, 1, 0, 0, 0, 0), 0, '0, '0);

      // bz at pc=7 with non-zero result -> not taken, C untouched by xor
      push_exp("bz_nt_pc", K_PC, 0, 64'd8);
      push_exp("bz_nt_res", K_RES, 0, 64'hFFFFFFFFDEADBEEF);
      push_exp("xor_keeps_c", K_C, 0, 64'd1);
      run_instr({6'h04, 5'd6, 5'd0, 16'hFFFE}, mk_ctl(0, 0, 3, 0, 0, 0, 4, 0), 0, '0, '0);

      // sra r7 = r6 >>> 4
      push_exp("sra_r7", K_REG, 7, 64'hFDEADBEE);
      push_exp("sra_func", K_FUNC, 0, 64'h03);
      push_exp("sra_pc", K_PC, 0, 64'd9);
      run_instr({6'h00, 5'd6, 5'd7, 5'd4, 5'd0, 6'h03}, mk_ctl(1, 1, 6, 2, 0, 0, 0, 0), 0, '0, '0);

      // halt at pc=9
      push_exp("halt_flag", K_HALT, 0, 64'd1);
      push_exp("halt_state", K_ST, 0, 64'd5);
      push_exp("halt_cycles", K_CYC, 0, 64'd2);
      run_instr(32'hFC000000, mk_ctl(0, 0, 0, 0, 0, 0, 0, 1), 0, '0, '0);
      halt_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("halt_no_fetch", 64'(mif.imem_req), 64'd0);
      end
      check_val("halt_pc", 64'(pc), 64'd9);
      check_val("halt_absorbing", 64'(state), 64'd5);

      // reset during a pending load abandons it
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mif.imem_rdata = {6'h23, 5'd0, 5'd9, 16'h0010};
      reg_dest = 2'd1; reg_write = 1'b1; alu_op = 3'd0; alu_src = 2'd1;
      mem_write = 1'b0; mem_to_reg = 2'd1; branch = 3'd0;
      for (int i = 0; i < 10 && state != 3'd3; i++) @(negedge clk);
      check_val("reach_mem", 64'(state), 64'd3);
      check_val("mem_req_pending", 64'(mif.dmem_req), 64'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("async_dmem_req", 64'(mif.dmem_req), 64'd0);
      check_val("async_state", 64'(state), 64'd0);
      check_val("async_pc", 64'(pc), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mif.imem_ready = 1'b0;
      mif.dmem_ready = 1'b1;
      mif.dmem_rdata = 32'hDEADBEEF;
      repeat (4) @(negedge clk);
      check_val("late_ready_r9", 64'(dut.rf_q[9]), 64'd0);
      check_val("late_ready_state", 64'(state), 64'd0);
      check_val("late_ready_dreq", 64'(mif.dmem_req), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
